// File: rtl/fifo_pkg.sv
// Shared definitions for the 32-bit synchronous FIFO and its read-side clients.
//
// Contents:
//   FIFO_DATA_WIDTH - FIFO word width
//   FIFO_CNT_WIDTH  - width of the FIFO's internal fill counter
//   rd_fsm_t        - read-client state encoding {IDLE, WAIT, SEND}
//   beats()         - number of output beats per FIFO word
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 32;
  localparam int unsigned FIFO_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } rd_fsm_t;

  // Beats needed to move one word; data_width must be a multiple of out_width.
  function automatic int unsigned beats(input int unsigned data_width,
                                        input int unsigned out_width);
    return data_width / out_width;
  endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Read-side client of the synchronous FIFO. Pops one word at a time (1-cycle read
// latency) and streams it out as OUT_WIDTH-bit beats, least-significant beat first,
// over a valid/ready handshake.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous, active-high reset
//   fifo_empty    - FIFO empty flag
//   fifo_data_out - FIFO read data, valid the cycle after a pop
//   fifo_rd_en    - FIFO pop request
//   out_data      - current beat
//   out_valid     - beat valid
//   out_ready     - downstream accepts beat
//   busy          - a word is in flight
//   words_read    - count of fully transmitted words (wraps)
//
// Build option:
//   FIFO_RD_PREFETCH_EN - when defined, the next word is popped on the last-beat
//                         handshake so the serializer skips IDLE between words.
module fifo_rd_serializer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_read
);

  localparam int unsigned BEATS     = beats(DATA_WIDTH, OUT_WIDTH);
  // Keep the counter at least one bit wide so a single-beat build still elaborates.
  localparam int unsigned BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  rd_fsm_t               state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  words_read_q, words_read_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    beat_cnt_d   = beat_cnt_q;
    words_read_d = words_read_q;
    fifo_rd_en   = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;

    unique case (state_q)
      IDLE: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) begin
          state_d = WAIT;
        end
      end

      // Popped word appears on fifo_data_out this cycle.
      WAIT: begin
        shreg_d    = fifo_data_out;
        beat_cnt_d = '0;
        state_d    = SEND;
      end

      SEND: begin
        out_valid = 1'b1;
        out_data  = shreg_q[OUT_WIDTH-1:0];
        if (out_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            words_read_d = words_read_q + 1'b1;
`ifdef FIFO_RD_PREFETCH_EN
            fifo_rd_en = !fifo_empty;
            state_d    = fifo_empty ? IDLE : WAIT;
`else
            state_d    = IDLE;
`endif
          end else begin
            shreg_d    = shreg_q >> OUT_WIDTH;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      beat_cnt_q   <= '0;
      words_read_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      beat_cnt_q   <= beat_cnt_d;
      words_read_q <= words_read_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign words_read = words_read_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer with a behavioural FIFO in front of it and a
// beat scoreboard behind it. The counter is built 2 bits wide so wrap is reachable.
module tb_fifo_rd_serializer;

  localparam int unsigned DW    = 32;
  localparam int unsigned OW    = 8;
  localparam int unsigned CW    = 2;
  localparam int unsigned BEATS = DW / OW;
`ifdef FIFO_RD_PREFETCH_EN
  localparam int WORD_GAP = 2;
`else
  localparam int WORD_GAP = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_en;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] words_read;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  int            pop_cnt = 0;
  logic [DW-1:0] fq[$];

  always #5 clk = ~clk;

  fifo_rd_serializer #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .words_read   (words_read)
  );

  // Synchronous FIFO model: registered empty flag, data valid one cycle after pop.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data_out <= fq.pop_front();
      pop_cnt       <= pop_cnt + 1;
    end
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            pushes = 0;
  int            beat_idx = 0;
  logic [CW-1:0] exp_words = '0;
  logic [OW-1:0] exp_q[$];
  int            hs_cyc[$];
  int            rd_cyc[$];
  logic [CW-1:0] wr_seq[$];
  logic [CW-1:0] last_wr = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [OW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic step();
    logic [OW-1:0] e;
    @(negedge clk);
    cyc++;
    check("words_read", words_read, exp_words);
    check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
`ifndef FIFO_RD_PREFETCH_EN
    check("rd_en_outside_idle", fifo_rd_en & busy, 0);
`endif
    if (prev_valid && !prev_ready) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    if (words_read !== last_wr) begin
      wr_seq.push_back(words_read);
      last_wr = words_read;
    end
    if (fifo_rd_en) rd_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      check("beat_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat_data", out_data, e);
        beat_idx++;
        if (beat_idx == BEATS) begin
          beat_idx = 0;
          exp_words++;
        end
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    for (int i = 0; i < BEATS; i++) exp_q.push_back(w[i*OW +: OW]);
    pushes++;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] wrap_exp[5];
    logic          bp_pat[4];
    int            n;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bp_pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state, then idle with an empty FIFO.
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_words_read", words_read, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_valid", out_valid, 0);
    end
    check("idle_no_pop", rd_cyc.size(), 0);

    // Single word with ready held high.
    hs_cyc.delete();
    rd_cyc.delete();
    out_ready = 1'b1;
    push(32'hA1B2C3D4);
    n = 0;
    while (hs_cyc.size() < 4 && n < 20) begin
      step();
      n++;
    end
    check("single_beats", hs_cyc.size(), 4);
    check("single_pops", rd_cyc.size(), 1);
    if (hs_cyc.size() == 4 && rd_cyc.size() == 1) begin
      check("single_first_lat", hs_cyc[0] - rd_cyc[0], 2);
      check("single_last_lat", hs_cyc[3] - rd_cyc[0], 5);
    end
    step();
    check("single_idle", busy, 0);

    // Backpressure pattern 1,0,0,1 repeating.
    hs_cyc.delete();
    rd_cyc.delete();
    out_ready = 1'b0;
    push(32'hA1B2C3D4);
    n = 0;
    while (hs_cyc.size() < 4 && n < 40) begin
      out_ready = bp_pat[n % 4];
      step();
      n++;
    end
    check("bp_beats", hs_cyc.size(), 4);
    check("bp_pops", rd_cyc.size(), 1);
    check("bp_drained", exp_q.size(), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_no_extra", hs_cyc.size(), 4);

    // Back-to-back words.
    hs_cyc.delete();
    rd_cyc.delete();
    out_ready = 1'b1;
    push(32'h11223344);
    push(32'h55667788);
    n = 0;
    while (hs_cyc.size() < 8 && n < 40) begin
      step();
      n++;
    end
    check("b2b_beats", hs_cyc.size(), 8);
    check("b2b_pops", rd_cyc.size(), 2);
    if (hs_cyc.size() == 8) begin
      check("b2b_no_bubble", hs_cyc[3] - hs_cyc[0], 3);
      check("b2b_word_gap", hs_cyc[4] - hs_cyc[3], WORD_GAP);
    end
    for (int i = 0; i < 3; i++) step();
    check("b2b_idle", busy, 0);

    // Reset after the second beat of a word.
    hs_cyc.delete();
    push(32'hDEADBEEF);
    n = 0;
    while (hs_cyc.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check("mid_two_beats", hs_cyc.size(), 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_words", words_read, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    check("mid_rst_data", out_data, 0);
    exp_q.delete();
    beat_idx   = 0;
    exp_words  = '0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs_cyc.delete();
    for (int i = 0; i < 10; i++) step();
    check("mid_no_beats", hs_cyc.size(), 0);

    // Counter wrap over five words.
    wr_seq.delete();
    last_wr = words_read;
    hs_cyc.delete();
    push(32'h01020304);
    push(32'h05060708);
    push(32'h090A0B0C);
    push(32'h0D0E0F10);
    push(32'h11121314);
    n = 0;
    while (hs_cyc.size() < 20 && n < 100) begin
      step();
      n++;
    end
    step();
    check("wrap_beats", hs_cyc.size(), 20);
    check("wrap_seq_len", wr_seq.size(), 5);
    if (wr_seq.size() == 5) begin
      for (int i = 0; i < 5; i++) check("wrap_seq", wr_seq[i], wrap_exp[i]);
    end
    check("wrap_final", words_read, 1);
    check("one_pop_per_word", pop_cnt, pushes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
